// File: rtl/calc_core.sv
// rtl/calc_core.sv - sign-magnitude calculator core: 1-cycle add/sub, W-cycle iterative multiply/divide
module calc_core #(
    parameter int W = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   num1,
    input  logic [W-1:0]   num2,
    input  logic           sig1,
    input  logic [1:0]     oper,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] result,
    output logic           res_neg,
    output logic           err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ADDSUB = 3'd1;
    localparam logic [2:0] S_MUL    = 3'd2;
    localparam logic [2:0] S_DIV    = 3'd3;
    localparam logic [2:0] S_FIN    = 3'd4;

    localparam logic [3:0] LAST_ITER = 4'(W - 1);

    logic [2:0]     state;
    logic [3:0]     cnt;
    logic           sig_r;
    logic [1:0]     op_r;
    logic [W-1:0]   n1_r;
    logic [W-1:0]   n2_r;
    logic [2*W-1:0] acc;
    logic [2*W-1:0] mcand;
    logic [W-1:0]   q;
    logic [W:0]     rem;

    // q doubles as the multiplier shift register and the dividend/quotient register
    logic [W:0]   rem_sh;
    logic [W+1:0] rem_diff;

    assign rem_sh   = {rem[W-1:0], q[W-1]};
    assign rem_diff = {1'b0, rem_sh} - {2'b00, n2_r};

    logic signed [W+1:0] a_s;
    logic signed [W+1:0] b_s;
    logic signed [W+1:0] as_sum;
    logic [W+1:0]        as_u;
    logic [W+1:0]        as_mag;

    assign a_s    = sig_r ? -$signed({2'b00, n1_r}) : $signed({2'b00, n1_r});
    assign b_s    = $signed({2'b00, n2_r});
    assign as_sum = op_r[0] ? (a_s - b_s) : (a_s + b_s);
    assign as_u   = as_sum;
    assign as_mag = as_sum[W+1] ? -as_u : as_u;

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            sig_r   <= 1'b0;
            op_r    <= '0;
            n1_r    <= '0;
            n2_r    <= '0;
            acc     <= '0;
            mcand   <= '0;
            q       <= '0;
            rem     <= '0;
            done    <= 1'b0;
            result  <= '0;
            res_neg <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sig_r <= sig1;
                        op_r  <= oper;
                        n1_r  <= num1;
                        n2_r  <= num2;
                        cnt   <= '0;
                        acc   <= '0;
                        rem   <= '0;
                        mcand <= {{W{1'b0}}, num1};
                        q     <= (oper == 2'd2) ? num2 : num1;
                        if (oper[1] == 1'b0)
                            state <= S_ADDSUB;
                        else if (oper == 2'd2)
                            state <= S_MUL;
                        else
                            state <= S_DIV;
                    end
                end
                S_ADDSUB: state <= S_FIN;
                S_MUL: begin
                    acc   <= acc + (q[0] ? mcand : '0);
                    mcand <= {mcand[2*W-2:0], 1'b0};
                    q     <= {1'b0, q[W-1:1]};
                    cnt   <= cnt + 4'd1;
                    if (cnt == LAST_ITER)
                        state <= S_FIN;
                end
                S_DIV: begin
                    // Restoring step: keep the subtraction only when it does not go negative
                    if (!rem_diff[W+1]) begin
                        rem <= rem_diff[W:0];
                        q   <= {q[W-2:0], 1'b1};
                    end else begin
                        rem <= rem_sh;
                        q   <= {q[W-2:0], 1'b0};
                    end
                    cnt <= cnt + 4'd1;
                    if (cnt == LAST_ITER)
                        state <= S_FIN;
                end
                S_FIN: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                    cnt   <= '0;
                    case (op_r)
                        2'd2: begin
                            result  <= acc;
                            res_neg <= sig_r && (acc != '0);
                            err     <= 1'b0;
                        end
                        2'd3: begin
                            if (n2_r == '0) begin
                                result  <= '0;
                                res_neg <= 1'b0;
                                err     <= 1'b1;
                            end else begin
                                result  <= {{W{1'b0}}, q};
                                res_neg <= sig_r && (q != '0);
                                err     <= 1'b0;
                            end
                        end
                        default: begin
                            result  <= {{(W-2){1'b0}}, as_mag};
                            res_neg <= as_sum[W+1];
                            err     <= 1'b0;
                        end
                    endcase
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_core.sv
// tb/tb_calc_core.sv - self-checking bench for calc_core with a cycle-level scoreboard model
module tb_calc_core;

    localparam int W = 10;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   num1 = '0;
    logic [W-1:0]   num2 = '0;
    logic           sig1 = 1'b0;
    logic [1:0]     oper = '0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] result;
    logic           res_neg;
    logic           err;

    calc_core #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num1(num1), .num2(num2),
        .sig1(sig1), .oper(oper), .busy(busy), .done(done), .result(result),
        .res_neg(res_neg), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int acc;
        int due;
        int res;
        int neg;
        int err;
    } op_t;

    op_t pq[$];
    int  free_edge = 0;
    int  last_res = 0, last_neg = 0, last_err = 0;
    int  total = 0, bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    // Expected outcome straight from the arithmetic rules of each operation
    task automatic model(input int s, input int n1, input int n2, input int op,
                         output int res, output int neg, output int er, output int lat);
        int a, r;
        er = 0;
        a = s ? -n1 : n1;
        if (op < 2) begin
            r   = (op == 0) ? a + n2 : a - n2;
            res = (r < 0) ? -r : r;
            neg = (r < 0) ? 1 : 0;
            lat = 2;
        end else if (op == 2) begin
            res = n1 * n2;
            neg = (s && res != 0) ? 1 : 0;
            lat = 11;
        end else begin
            lat = 11;
            if (n2 == 0) begin
                res = 0; neg = 0; er = 1;
            end else begin
                res = n1 / n2;
                neg = (s && res != 0) ? 1 : 0;
            end
        end
    endtask

    always @(negedge clk) begin
        int exp_done, exp_busy;
        exp_done = (pq.size() > 0 && pq[0].due == cyc) ? 1 : 0;
        exp_busy = (pq.size() > 0 && cyc >= pq[0].acc && cyc < pq[0].due) ? 1 : 0;
        if (exp_done == 1) begin
            last_res = pq[0].res;
            last_neg = pq[0].neg;
            last_err = pq[0].err;
            void'(pq.pop_front());
        end
        chk("done", int'(done), exp_done);
        chk("busy", int'(busy), exp_busy);
        chk("result", int'(result), last_res);
        chk("res_neg", int'(res_neg), last_neg);
        chk("err", int'(err), last_err);
    end

    task automatic wait_until(input int target);
        for (int g = 0; g < 100 && cyc < target; g++) @(negedge clk);
        if (cyc < target) chk("wait_timeout", cyc, target);
    endtask

    // Drives one start pulse sampled at edge cyc+1; the model decides whether it is accepted
    task automatic issue(input int s, input int n1, input int n2, input int op, output int e);
        op_t o;
        int lat;
        #2;
        sig1  = s[0];
        num1  = n1[W-1:0];
        num2  = n2[W-1:0];
        oper  = op[1:0];
        start = 1'b1;
        e = cyc + 1;
        if (e >= free_edge && rst_n) begin
            model(s, n1, n2, op, o.res, o.neg, o.err, lat);
            o.acc = e;
            o.due = e + lat;
            pq.push_back(o);
            free_edge = e + lat + 1;
        end
        @(negedge clk);
        #2 start = 1'b0;
    endtask

    task automatic run_op(input string nm, input int s, input int n1, input int n2, input int op,
                          input int lat, input int eres, input int eneg, input int eerr);
        int e;
        issue(s, n1, n2, op, e);
        wait_until(e + lat);
        #1;
        chk({nm, "_done"}, int'(done), 1);
        chk({nm, "_busy"}, int'(busy), 0);
        chk({nm, "_result"}, int'(result), eres);
        chk({nm, "_res_neg"}, int'(res_neg), eneg);
        chk({nm, "_err"}, int'(err), eerr);
    endtask

    initial begin
        int e, e1;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Reset in the middle of a long multiply
        issue(1, 999, 999, 2, e);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        pq.delete();
        last_res = 0; last_neg = 0; last_err = 0;
        free_edge = 0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("abort_result", int'(result), 0);

        run_op("add_neg", 1, 25, 10, 0, 2, 15, 1, 0);
        run_op("add_zero", 1, 10, 10, 0, 2, 0, 0, 0);
        run_op("sub", 0, 7, 120, 1, 2, 113, 1, 0);
        run_op("sub_max", 1, 999, 999, 1, 2, 1998, 1, 0);
        run_op("add_1023", 0, 1023, 1023, 0, 2, 2046, 0, 0);

        // Multiply with inputs disturbed and a stray start while busy
        issue(1, 999, 999, 2, e);
        for (int i = 0; i < 7; i++) begin
            if (i == 3) begin
                issue(0, 3, 5, 0, e1);
            end else begin
                @(negedge clk);
                #2;
                num1 = W'($urandom_range(0, 1023));
                sig1 = ~sig1;
                oper = 2'($urandom_range(0, 3));
            end
        end
        wait_until(e + 11);
        #1;
        chk("mul_result", int'(result), 998001);
        chk("mul_res_neg", int'(res_neg), 1);
        chk("mul_done", int'(done), 1);

        run_op("mul_1023", 0, 1023, 1023, 2, 11, 1046529, 0, 0);
        run_op("mul_zero", 1, 0, 55, 2, 11, 0, 0, 0);
        run_op("div", 0, 100, 7, 3, 11, 14, 0, 0);
        run_op("div_zero", 0, 100, 0, 3, 11, 0, 0, 1);
        run_op("add_clr", 0, 3, 4, 0, 2, 7, 0, 0);
        run_op("div_neg", 1, 1023, 1, 3, 11, 1023, 1, 0);
        run_op("div_negzero", 1, 5, 9, 3, 11, 0, 0, 0);

        // Back-to-back: starts during ADDSUB and FIN are dropped, start in the done cycle is taken
        issue(0, 5, 3, 0, e1);
        issue(0, 9, 9, 1, e);
        issue(0, 9, 9, 1, e);
        chk("b2b_done_cycle", int'(done), 1);
        chk("b2b_first", int'(result), 8);
        issue(0, 6, 7, 2, e);
        wait_until(e1 + 3 + 11);
        #1;
        chk("b2b_second_done", int'(done), 1);
        chk("b2b_second", int'(result), 42);

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
